// File: rtl/scarv_cop_aes_issue.sv
// Issue/writeback sequencer in front of the co-processor AES unit: holds one
// instruction stable for the unit's 4-cycle sequence, then presents its result.
module scarv_cop_aes_issue #(
    parameter int TIMEOUT = 8
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [31:0] dec_rs3,
    input  logic [31:0] dec_imm,
    input  logic [2:0]  dec_pw,
    input  logic [3:0]  dec_class,
    input  logic [4:0]  dec_subclass,
    input  logic [3:0]  dec_rd,
    input  logic        flush,

    output logic        aes_ivalid,
    output logic [31:0] aes_rs1,
    output logic [31:0] aes_rs2,
    output logic [31:0] aes_rs3,
    output logic [31:0] id_imm,
    output logic [2:0]  id_pw,
    output logic [3:0]  id_class,
    output logic [4:0]  id_subclass,
    input  logic        aes_idone,
    input  logic [3:0]  aes_cpr_rd_ben,
    input  logic [31:0] aes_cpr_rd_wdata,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [3:0]  wb_ben,
    output logic [31:0] wb_wdata,

    output logic        busy,
    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state_q;
    logic [31:0]   rs1_q, rs2_q, rs3_q, imm_q;
    logic [2:0]    pw_q;
    logic [3:0]    class_q;
    logic [4:0]    subclass_q;
    logic [3:0]    rd_q;
    logic [3:0]    ben_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt_q;
    logic          flush_pend_q;

    logic in_busy;
    logic in_done;
    logic accept;

    assign in_busy = (state_q == BUSY);
    assign in_done = (state_q == DONE);
    assign accept  = dec_valid && dec_ready;

    // NOTE: every holding register is reset as well, so no operand or result
    // from before the reset can ever reach the AES unit or the CPR port.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            imm_q        <= '0;
            pw_q         <= '0;
            class_q      <= '0;
            subclass_q   <= '0;
            rd_q         <= '0;
            ben_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch below sees
            // the pre-edge values of all registers regardless of order.
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= BUSY;
                        rs1_q        <= dec_rs1;
                        rs2_q        <= dec_rs2;
                        rs3_q        <= dec_rs3;
                        imm_q        <= dec_imm;
                        pw_q         <= dec_pw;
                        class_q      <= dec_class;
                        subclass_q   <= dec_subclass;
                        rd_q         <= dec_rd;
                        cnt_q        <= '0;
                        flush_pend_q <= 1'b0;
                    end
                end

                BUSY: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (aes_idone || (cnt_q == CNT_LAST)) begin
                        // Sequence over: operands are no longer needed.
                        rs1_q        <= '0;
                        rs2_q        <= '0;
                        rs3_q        <= '0;
                        imm_q        <= '0;
                        pw_q         <= '0;
                        class_q      <= '0;
                        subclass_q   <= '0;
                        flush_pend_q <= 1'b0;
                    end
                    if (aes_idone) begin
                        if (flush || flush_pend_q) begin
                            state_q <= IDLE;
                            rd_q    <= '0;
                        end else begin
                            state_q <= DONE;
                            ben_q   <= aes_cpr_rd_ben;
                            wdata_q <= aes_cpr_rd_wdata;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ERR;
                        rd_q    <= '0;
                    end else if (flush) begin
                        // The unit cannot be aborted; just drop its result later.
                        flush_pend_q <= 1'b1;
                    end
                end

                DONE: begin
                    if (flush || wb_ready) begin
                        state_q <= IDLE;
                        rd_q    <= '0;
                        ben_q   <= '0;
                        wdata_q <= '0;
                    end
                end

                ERR: begin
                    state_q <= ERR;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign dec_ready   = (state_q == IDLE) && !flush;
    assign busy        = (state_q != IDLE);
    assign err_timeout = (state_q == ERR);

    assign aes_ivalid  = in_busy;
    assign aes_rs1     = in_busy ? rs1_q      : '0;
    assign aes_rs2     = in_busy ? rs2_q      : '0;
    assign aes_rs3     = in_busy ? rs3_q      : '0;
    assign id_imm      = in_busy ? imm_q      : '0;
    assign id_pw       = in_busy ? pw_q       : '0;
    assign id_class    = in_busy ? class_q    : '0;
    assign id_subclass = in_busy ? subclass_q : '0;

    assign wb_valid    = in_done;
    assign wb_rd       = in_done ? rd_q    : '0;
    assign wb_ben      = in_done ? ben_q   : '0;
    assign wb_wdata    = in_done ? wdata_q : '0;

endmodule
